// File: rtl/frame_capture_ctrl_if.sv
// Frame buffer port bundle between the capture controller and the dual-port
// frame buffer.
//   master (controller): drives the write port (wr_en, wr_addr, wr_data) and
//                        the read address (rd_addr); receives rd_data.
//   slave  (buffer)    : receives the write port and rd_addr; returns rd_data
//                        one clock after rd_addr (synchronous read).
// DATA_W is the beat width, PIX_W*PIX_PER_BEAT on the controller side.
interface frame_capture_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, output wr_addr, output wr_data,
                  output rd_addr, input rd_data);
  modport slave  (input wr_en, input wr_addr, input wr_data,
                  input rd_addr, output rd_data);
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame capture / display readout controller for the camera path.
// Write side turns qualified pixel beats and FS/LE/FE strobes into frame
// buffer writes into the current capture bank; read side turns display x/y
// into buffer reads from the last complete bank and picks the pixel lane.
// Ports:
//   clk, rst_n                 single clock, synchronous active-low reset
//   arm, continuous, stop      capture control (arm samples continuous)
//   frame_start/end, line_end  sync strobes from the unpacker
//   beat_valid, beat_data      pixel beats, lane 0 (leftmost) in the LSBs
//   rd_x, rd_y                 display coordinates
//   rd_pixel                   selected pixel, 3 cycles after rd_x/rd_y
//   disp_valid, busy           a complete frame exists / controller active
//   frame_count                complete frames captured (wraps)
//   err_short, err_overrun     sticky error flags
//   buf_bus                    frame buffer write port and read port
module frame_capture_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PIX_W        = 8,
  parameter int PIX_PER_BEAT = 4,
  parameter int NUM_BANKS    = 2,
  parameter int ADDR_W       = 18
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arm,
  input  logic                          continuous,
  input  logic                          stop,
  input  logic                          frame_start,
  input  logic                          frame_end,
  input  logic                          line_end,
  input  logic                          beat_valid,
  input  logic [PIX_W*PIX_PER_BEAT-1:0] beat_data,
  input  logic [9:0]                    rd_x,
  input  logic [9:0]                    rd_y,
  output logic [PIX_W-1:0]              rd_pixel,
  output logic                          disp_valid,
  output logic                          busy,
  output logic [15:0]                   frame_count,
  output logic                          err_short,
  output logic                          err_overrun,
  frame_capture_ctrl_if.master          buf_bus
);
  localparam int BPL        = H_ACTIVE / PIX_PER_BEAT;
  localparam int BANK_WORDS = BPL * V_ACTIVE;
  localparam int COL_W      = $clog2(BPL + 1);
  localparam int LINE_W     = $clog2(V_ACTIVE + 1);
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LANE_W     = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(BPL);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_ACTIVE);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);
  // One bit wider than rd_x/rd_y so a 1024-wide limit still compares right.
  localparam logic [10:0]       X_LIM     = 11'(H_ACTIVE);
  localparam logic [10:0]       Y_LIM     = 11'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_FS, CAPTURE, DONE} state_t;

  state_t              state, state_nxt;
  logic                cont_q;
  logic                stop_pend;
  logic [LINE_W-1:0]   line, line_inc, line_le;
  logic [COL_W-1:0]    col, col_inc;
  logic [BANK_W-1:0]   wr_bank, disp_bank, bank_next;
  logic                beat_ok, frame_ok;
  logic [ADDR_W-1:0]   wr_base, disp_base;

  logic [LANE_W-1:0]   lane_p0, lane_p1;
  logic                blank_p0, blank_p1;

  assign busy = (state != IDLE);

  assign beat_ok   = (line < LINE_MAX) && (col < COL_MAX);
  assign col_inc   = (col == COL_MAX) ? col : col + 1'b1;
  assign line_inc  = (line == LINE_MAX) ? line : line + 1'b1;
  // Strobe order within a cycle is beat, then LE, then FE: completeness is
  // judged on the line count after any same-cycle line_end.
  assign line_le   = line_end ? line_inc : line;
  assign frame_ok  = (line_le == LINE_MAX);
  assign bank_next = (wr_bank == BANK_LAST) ? '0 : wr_bank + 1'b1;
  assign wr_base   = ADDR_W'(wr_bank) * ADDR_W'(BANK_WORDS);
  assign disp_base = ADDR_W'(disp_bank) * ADDR_W'(BANK_WORDS);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = WAIT_FS;
      WAIT_FS: begin
        if (stop)             state_nxt = IDLE;
        else if (frame_start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (frame_end) begin
          if (!cont_q)                state_nxt = DONE;
          else if (stop_pend || stop) state_nxt = IDLE;
          else                        state_nxt = WAIT_FS;
        end
      end
      DONE:    if (arm) state_nxt = WAIT_FS;
      default: state_nxt = IDLE;
    endcase
  end

  // Write side: beat counters, bank swap, status and the 1-cycle write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cont_q          <= 1'b0;
      stop_pend       <= 1'b0;
      line            <= '0;
      col             <= '0;
      wr_bank         <= '0;
      disp_bank       <= '0;
      disp_valid      <= 1'b0;
      frame_count     <= '0;
      err_short       <= 1'b0;
      err_overrun     <= 1'b0;
      buf_bus.wr_en   <= 1'b0;
      buf_bus.wr_addr <= '0;
      buf_bus.wr_data <= '0;
    end else begin
      buf_bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            cont_q    <= continuous;
            stop_pend <= 1'b0;
          end
        end
        WAIT_FS: begin
          if (frame_start) begin
            line      <= '0;
            col       <= '0;
            stop_pend <= 1'b0;
          end
        end
        CAPTURE: begin
          if (beat_valid) begin
            if (beat_ok) begin
              buf_bus.wr_en   <= 1'b1;
              buf_bus.wr_addr <= wr_base + ADDR_W'(line) * ADDR_W'(BPL) + ADDR_W'(col);
              buf_bus.wr_data <= beat_data;
            end else begin
              err_overrun <= 1'b1;
            end
            col <= col_inc;
          end
          if (line_end) begin
            line <= line_inc;
            col  <= '0;
            if (line == LINE_MAX) err_overrun <= 1'b1;
          end
          if (cont_q && stop) stop_pend <= 1'b1;
          if (frame_end) begin
            if (frame_ok) begin
              disp_bank   <= wr_bank;
              disp_valid  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              wr_bank     <= bank_next;
            end else begin
              err_short <= 1'b1;
            end
          end else if (frame_start) begin
            // FE was lost: start over in the same bank.
            err_overrun <= 1'b1;
            line        <= '0;
            col         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_bus.rd_addr <= '0;
      lane_p0         <= '0;
      lane_p1         <= '0;
      blank_p0        <= 1'b1;
      blank_p1        <= 1'b1;
      rd_pixel        <= '0;
    end else begin
      // c1: read address, lane and blanking decision
      buf_bus.rd_addr <= disp_base + ADDR_W'(rd_y) * ADDR_W'(BPL)
                         + ADDR_W'(rd_x / PIX_PER_BEAT);
      lane_p0  <= LANE_W'(rd_x % PIX_PER_BEAT);
      blank_p0 <= !disp_valid || ({1'b0, rd_x} >= X_LIM) || ({1'b0, rd_y} >= Y_LIM);
      // c2: buffer returns rd_data
      lane_p1  <= lane_p0;
      blank_p1 <= blank_p0;
      // c3: lane select
      rd_pixel <= blank_p1 ? '0 : buf_bus.rd_data[lane_p1*PIX_W +: PIX_W];
    end
  end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl with H=8, V=4, 4 pixels/beat, 2 banks.
// A small synchronous-read RAM stands in for the frame buffer; expected
// writes are queued as beats are driven and popped as wr_en appears.
module tb_frame_capture_ctrl;
  localparam int H = 8, V = 4, PPB = 4, NB = 2, AW = 18, PW = 8, BW = 32;
  localparam int BPL = 2, BANK_WORDS = 8;

  logic          clk = 1'b0;
  logic          rst_n, arm, continuous, stop;
  logic          frame_start, frame_end, line_end, beat_valid;
  logic [BW-1:0] beat_data;
  logic [9:0]    rd_x, rd_y;
  logic [PW-1:0] rd_pixel;
  logic          disp_valid, busy, err_short, err_overrun;
  logic [15:0]   frame_count;

  frame_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(BW)) bus ();

  frame_capture_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .PIX_PER_BEAT(PPB),
    .NUM_BANKS(NB), .ADDR_W(AW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .continuous(continuous), .stop(stop),
    .frame_start(frame_start), .frame_end(frame_end), .line_end(line_end),
    .beat_valid(beat_valid), .beat_data(beat_data), .rd_x(rd_x), .rd_y(rd_y),
    .rd_pixel(rd_pixel), .disp_valid(disp_valid), .busy(busy),
    .frame_count(frame_count), .err_short(err_short), .err_overrun(err_overrun),
    .buf_bus(bus)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] mem [0:15];
  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr[3:0]] <= bus.wr_data;
    bus.rd_data <= mem[bus.rd_addr[3:0]];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;
  wr_t wr_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (bus.wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 32'(bus.wr_en), 32'd0);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", bus.wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic fs, input logic fe, input logic le,
                     input logic bv, input logic [BW-1:0] d);
    frame_start = fs; frame_end = fe; line_end = le; beat_valid = bv; beat_data = d;
    tick();
    frame_start = 1'b0; frame_end = 1'b0; line_end = 1'b0; beat_valid = 1'b0;
  endtask

  task automatic pulse_arm(input logic c);
    continuous = c;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Drives one frame; every beat inside the H/V window is expected at
  // bank*BANK_WORDS + line*BPL + beat. With merge, the last beat of a line
  // shares its cycle with LE (and with FE on the last line).
  task automatic send_frame(input int bank, input int nlines, input int beats,
                            input bit merge, input bit fixed,
                            input bit do_fs, input bit do_fe);
    logic [BW-1:0] d;
    bit last_b, last_l;
    if (do_fs) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int l = 0; l < nlines; l++) begin
      for (int b = 0; b < beats; b++) begin
        d = fixed ? 32'h44332211 : $urandom;
        last_b = (b == beats - 1);
        last_l = (l == nlines - 1);
        if (l < V && b < BPL) wr_q.push_back({AW'(bank*BANK_WORDS + l*BPL + b), d});
        if (merge && last_b) begin
          cyc(1'b0, last_l && do_fe, 1'b1, 1'b1, d);
        end else begin
          cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
          if (last_b) cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
      end
    end
    if (do_fe && !merge) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic rd_check(input int x, input int y, input logic [AW-1:0] ea,
                          input logic [PW-1:0] ep);
    rd_x = 10'(x);
    rd_y = 10'(y);
    tick();
    chk("rd_addr", 32'(bus.rd_addr), 32'(ea));
    tick();
    tick();
    chk("rd_pixel", 32'(rd_pixel), 32'(ep));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; continuous = 1'b0; stop = 1'b0;
    frame_start = 1'b0; frame_end = 1'b0; line_end = 1'b0; beat_valid = 1'b0;
    beat_data = '0; rd_x = '0; rd_y = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_wr_en",       32'(bus.wr_en), 32'd0);
    chk("rst_busy",        32'(busy), 32'd0);
    chk("rst_disp_valid",  32'(disp_valid), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_err_short",   32'(err_short), 32'd0);
    chk("rst_err_overrun", 32'(err_overrun), 32'd0);
    chk("rst_rd_pixel",    32'(rd_pixel), 32'd0);

    // single-shot frame into bank 0
    pulse_arm(1'b0);
    chk("arm_busy", 32'(busy), 32'd1);
    send_frame(0, 4, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("ss_frame_count", 32'(frame_count), 32'd1);
    chk("ss_disp_valid",  32'(disp_valid), 32'd1);
    chk("ss_busy_done",   32'(busy), 32'd1);
    chk("ss_sb_empty",    32'(wr_q.size()), 32'd0);
    rd_check(5, 1, 18'd3, 8'h22);
    rd_check(9, 1, 18'd4, 8'h00);
    rd_check(2, 3, 18'd6, 8'h33);
    rd_check(1, 4, 18'd8, 8'h00);

    // continuous: banks alternate, stop acted on at the end of the 3rd frame
    pulse_arm(1'b1);
    send_frame(1, 4, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("c1_frame_count", 32'(frame_count), 32'd2);
    chk("c1_busy",        32'(busy), 32'd1);
    rd_check(3, 2, 18'd12, 8'h44);
    send_frame(0, 4, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("c2_frame_count", 32'(frame_count), 32'd3);
    rd_check(3, 2, 18'd4, 8'h44);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("c3_busy_mid", 32'(busy), 32'd1);
    send_frame(1, 4, 2, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("c3_frame_count", 32'(frame_count), 32'd4);
    chk("c3_busy_idle",   32'(busy), 32'd0);
    chk("c_sb_empty",     32'(wr_q.size()), 32'd0);
    rd_check(3, 2, 18'd12, 8'h44);

    // short frame: error, no swap
    pulse_arm(1'b0);
    send_frame(0, 3, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sh_err_short",   32'(err_short), 32'd1);
    chk("sh_frame_count", 32'(frame_count), 32'd4);
    chk("sh_err_overrun", 32'(err_overrun), 32'd0);
    chk("sh_busy_done",   32'(busy), 32'd1);
    rd_check(3, 2, 18'd12, 8'h44);

    // overrun: 3 beats/line and a 5th line, then FS mid-frame restarts
    pulse_arm(1'b0);
    send_frame(0, 5, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ov_err_overrun", 32'(err_overrun), 32'd1);
    chk("ov_sb_empty",    32'(wr_q.size()), 32'd0);
    send_frame(0, 4, 2, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("ov_frame_count", 32'(frame_count), 32'd5);
    chk("ov_sb_empty2",   32'(wr_q.size()), 32'd0);
    rd_check(3, 2, 18'd4, 8'h44);

    // reset in the middle of a capture
    pulse_arm(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    wr_q.push_back({AW'(8), 32'hCAFE0001});
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE0001);
    rst_n = 1'b0;
    beat_valid = 1'b1;
    beat_data = 32'hDEAD0000;
    tick();
    rst_n = 1'b1;
    beat_valid = 1'b0;
    chk("mr_wr_en",       32'(bus.wr_en), 32'd0);
    chk("mr_busy",        32'(busy), 32'd0);
    chk("mr_disp_valid",  32'(disp_valid), 32'd0);
    chk("mr_frame_count", 32'(frame_count), 32'd0);
    chk("mr_err_overrun", 32'(err_overrun), 32'd0);
    chk("mr_err_short",   32'(err_short), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'(i));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    tick();
    chk("mr_sb_empty", 32'(wr_q.size()), 32'd0);
    chk("mr_frame_count2", 32'(frame_count), 32'd0);
    rd_check(5, 1, 18'd3, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Parametrised frame-capture and display-readout controller for the CSI-2 camera path.
- Sits between the raw8 unpacker and the dual-port frame buffer.
  - Write side: turns qualified pixel beats plus frame/line sync strobes into buffer writes.
  - Read side: turns HDMI x/y into buffer reads with per-pixel lane select.
- Supports single-shot and continuous capture with N-bank ping-pong buffering.
  - Display always shows the last complete frame.

Parameters:
- H_ACTIVE, 640, pixels per captured line.
- V_ACTIVE, 480, lines per captured frame.
- PIX_W, 8, bits per pixel.
- PIX_PER_BEAT, 4, pixels per input beat (power of 2); beat width = PIX_W*PIX_PER_BEAT.
- NUM_BANKS, 2, frame banks in buffer (1..4); 1 disables ping-pong.
- ADDR_W, 18, buffer word address width; must hold NUM_BANKS*H_ACTIVE*V_ACTIVE/PIX_PER_BEAT.

Ports:
- clk  in  1  single clock, write and read side.
- rst_n  in  1  synchronous active-low reset.
- arm  in  1  one-cycle pulse: start capture.
- continuous  in  1  sampled on arm: 1 = continuous, 0 = single-shot.
- stop  in  1  one-cycle pulse: leave continuous mode at next frame boundary.
- frame_start  in  1  one-cycle FS strobe.
- frame_end  in  1  one-cycle FE strobe.
- line_end  in  1  one-cycle LE strobe.
- beat_valid  in  1  one-cycle strobe, one per pixel beat.
- beat_data  in  PIX_W*PIX_PER_BEAT  pixels; lane 0 = leftmost, in LSBs.
- wr_en  out  1  buffer write enable.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  PIX_W*PIX_PER_BEAT  buffer write data.
- rd_x  in  10  display x.
- rd_y  in  10  display y.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  PIX_W*PIX_PER_BEAT  buffer read data (one-cycle synchronous read).
- rd_pixel  out  PIX_W  selected pixel.
- disp_valid  out  1  at least one complete frame is available.
- busy  out  1  state != IDLE.
- frame_count  out  16  complete frames captured, wraps.
- err_short  out  1  sticky: frame ended with fewer than V_ACTIVE lines.
- err_overrun  out  1  sticky: beats or lines beyond H/V dropped, or FS seen mid-frame.

Behaviour:
- Reset (rst_n=0 at posedge): all of the following cleared, mid-frame included; no partial writes after reset.
  - State IDLE.
  - Outputs: wr_en, wr_addr, wr_data, rd_addr, rd_pixel, disp_valid, busy, frame_count, err_* = 0.
  - Internal: wr_bank=0, disp_bank=0.
- Derived constants: BPL = H_ACTIVE/PIX_PER_BEAT; BANK_WORDS = BPL*V_ACTIVE.
- FSM states: IDLE, WAIT_FS, CAPTURE, DONE.
  - IDLE: arm -> WAIT_FS; latch continuous.
  - WAIT_FS: frame_start -> CAPTURE with line=0, col=0. Beats, line_end and frame_end are ignored.
  - CAPTURE, on beat_valid:
    - If line<V_ACTIVE and col<BPL: next cycle wr_en=1, wr_addr = wr_bank*BANK_WORDS + line*BPL + col, wr_data = beat_data.
    - Otherwise: no write, set err_overrun.
    - col increments, saturating at BPL.
  - CAPTURE, on line_end: line++ (saturating at V_ACTIVE), col=0.
  - CAPTURE, on frame_end:
    - Complete (line==V_ACTIVE): disp_bank <= wr_bank, disp_valid <= 1, frame_count++, wr_bank <= (wr_bank+1) mod NUM_BANKS.
    - Incomplete: set err_short; banks unchanged (display keeps last good frame).
    - Then: single-shot -> DONE; continuous and no pending stop -> WAIT_FS; pending stop -> IDLE.
  - CAPTURE, frame_start (missed FE): set err_overrun, restart at line=0, col=0 in the same bank, no swap.
  - DONE: arm -> WAIT_FS (recapture); otherwise hold.
- stop: latched as pending while in continuous CAPTURE and acted on at frame_end. In WAIT_FS -> IDLE immediately. Ignored in IDLE and DONE.
- Simultaneous strobes in the same cycle, applied in order: beat_valid, then line_end, then frame_end (the beat lands on the old line).
- arm is ignored outside IDLE and DONE.
- wr_en is high for exactly one cycle per accepted beat; write latency is 1 cycle.
- Read path, 3-cycle pipeline:
  - c1: rd_addr = disp_bank*BANK_WORDS + rd_y*BPL + rd_x/PIX_PER_BEAT. Lane = rd_x mod PIX_PER_BEAT, piped along.
  - c2: rd_data returns.
  - c3: rd_pixel = lane slice of rd_data, or 0 if disp_valid=0, rd_x>=H_ACTIVE or rd_y>=V_ACTIVE.
- All address arithmetic is unsigned at ADDR_W; no wrap past the bank end because of the H/V clipping.

Test Plan:
- H=8, V=4, PIX_PER_BEAT=4, NUM_BANKS=2, single-shot: arm, FS, 4 lines of 2 beats with LE, FE -> 8 writes at addr 0..7, frame_count=1, disp_valid=1, state DONE, wr_bank=1.
- Continuous mode, 3 full frames -> writes start at bank bases 0, 8, 0; disp_bank = 0, 1, 0 after each FE; stop during frame 3 -> IDLE after that FE.
- Frame with 3 lines then FE -> err_short=1, disp_bank unchanged, frame_count unchanged, no swap.
- 3 beats in one line (BPL=2) and a 5th line -> extra beat and line not written, err_overrun=1; FS mid-CAPTURE -> restart at addr = bank base.
- After one frame of beat_data=32'h44332211 per beat: rd_x=5, rd_y=1 -> rd_addr=3, rd_pixel=8'h22 three cycles later; rd_x=9 -> rd_pixel=0.
- rst_n low mid-CAPTURE for 1 cycle -> next cycle wr_en=0, busy=0, disp_valid=0, frame_count=0; following beats produce no writes.
